// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcodes, func3/func7 codes, ALU op enum.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package exec_pkg;

  // Major opcodes handled by the execute stage
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  // func3 codes (shared by R-type and I-type arithmetic)
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // func7 codes recognised on R-type instructions
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_SLL,
    ALU_SLT,
    ALU_SLTU,
    ALU_XOR,
    ALU_SRL,
    ALU_SRA,
    ALU_OR,
    ALU_AND,
    ALU_PASSB,
    ALU_NOP
  } aluOp_t;

endpackage

// File: rtl/exec_if.sv
// Bundles the decoded-instruction inputs and the registered result outputs of exec_stage.
// Latency: n/a (wiring only).
// Backpressure: none; a new instruction is presented every cycle.
// Ports: slave = the execute stage (consumes operands, drives results);
//        master = the upstream/downstream side (drives operands, observes results).
interface exec_if #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
);
  logic [DATA_W-1:0]     dataReg1;
  logic [DATA_W-1:0]     dataReg2;
  logic [DATA_W-1:0]     immValueReg;
  logic [6:0]            ALUopcodeReg;
  logic [2:0]            ALUFunc3Reg;
  logic [6:0]            ALUFunc7Reg;
  logic                  writeEnableReg;
  logic [REG_ADDR_W-1:0] writeBackAddrIn;
  logic                  writeEnableOut;
  logic [REG_ADDR_W-1:0] writeBackAddrOut;
  logic [DATA_W-1:0]     dataOut;

  modport master (
    output dataReg1, dataReg2, immValueReg, ALUopcodeReg, ALUFunc3Reg, ALUFunc7Reg,
           writeEnableReg, writeBackAddrIn,
    input  writeEnableOut, writeBackAddrOut, dataOut
  );

  modport slave (
    input  dataReg1, dataReg2, immValueReg, ALUopcodeReg, ALUFunc3Reg, ALUFunc7Reg,
           writeEnableReg, writeBackAddrIn,
    output writeEnableOut, writeBackAddrOut, dataOut
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational integer ALU; wraps modulo 2^DATA_W, no flags.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: op (operation select), a/b (operands), result.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  aluOp_t            op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  localparam int SHAMT_W = $clog2(DATA_W);

  logic [SHAMT_W-1:0] shamt;

  // Only the low bits of b are a shift amount; the rest are ignored.
  assign shamt = b[SHAMT_W-1:0];

  always_comb begin
    result = '0;
    unique case (op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_SLL:   result = a << shamt;
      ALU_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, (a < b)};
      ALU_XOR:   result = a ^ b;
      ALU_SRL:   result = a >> shamt;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
      ALU_OR:    result = a | b;
      ALU_AND:   result = a & b;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: DEC/EX register, ALU-control decode + ALU, EX/MEM register.
// Latency: 2 clk edges from inputs to outputs; one instruction accepted per cycle.
// Backpressure: none; the pipeline never stalls.
// Ports: clk, resetIn (async active-low), bus (exec_if.slave: operands in, result out).
module exec_stage
  import exec_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic   clk,
  input  logic   resetIn,
  exec_if.slave  bus
);

  // Stage 1 (DEC/EX) contents
  logic [DATA_W-1:0]     s1Rs1;
  logic [DATA_W-1:0]     s1Rs2;
  logic [DATA_W-1:0]     s1Imm;
  logic [6:0]            s1Opcode;
  logic [2:0]            s1Func3;
  logic [6:0]            s1Func7;
  logic                  s1We;
  logic [REG_ADDR_W-1:0] s1Addr;

  // Stage 2 (EX/MEM) contents
  logic                  s2We;
  logic [REG_ADDR_W-1:0] s2Addr;
  logic [DATA_W-1:0]     s2Data;

  // Decode results
  aluOp_t            aluOp;
  logic              opValid;
  logic [DATA_W-1:0] operandB;
  logic [DATA_W-1:0] aluResult;

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      s1Rs1    <= '0;
      s1Rs2    <= '0;
      s1Imm    <= '0;
      s1Opcode <= '0;
      s1Func3  <= '0;
      s1Func7  <= '0;
      s1We     <= 1'b0;
      s1Addr   <= '0;
    end else begin
      s1Rs1    <= bus.dataReg1;
      s1Rs2    <= bus.dataReg2;
      s1Imm    <= bus.immValueReg;
      s1Opcode <= bus.ALUopcodeReg;
      s1Func3  <= bus.ALUFunc3Reg;
      s1Func7  <= bus.ALUFunc7Reg;
      s1We     <= bus.writeEnableReg;
      s1Addr   <= bus.writeBackAddrIn;
    end
  end

  // ALU control. Anything not recognised maps to ALU_NOP with opValid low,
  // which yields a zero result and suppresses the register write.
  always_comb begin
    aluOp    = ALU_NOP;
    opValid  = 1'b0;
    operandB = s1Rs2;
    unique case (s1Opcode)
      OP_R: begin
        operandB = s1Rs2;
        if (s1Func7 == F7_BASE) begin
          opValid = 1'b1;
          unique case (s1Func3)
            F3_ADD_SUB: aluOp = ALU_ADD;
            F3_SLL:     aluOp = ALU_SLL;
            F3_SLT:     aluOp = ALU_SLT;
            F3_SLTU:    aluOp = ALU_SLTU;
            F3_XOR:     aluOp = ALU_XOR;
            F3_SRL_SRA: aluOp = ALU_SRL;
            F3_OR:      aluOp = ALU_OR;
            default:    aluOp = ALU_AND;
          endcase
        end else if (s1Func7 == F7_ALT) begin
          // The alternate func7 is only meaningful for SUB and SRA.
          if (s1Func3 == F3_ADD_SUB) begin
            aluOp   = ALU_SUB;
            opValid = 1'b1;
          end else if (s1Func3 == F3_SRL_SRA) begin
            aluOp   = ALU_SRA;
            opValid = 1'b1;
          end
        end
      end
      OP_I: begin
        operandB = s1Imm;
        opValid  = 1'b1;
        unique case (s1Func3)
          F3_ADD_SUB: aluOp = ALU_ADD;
          F3_SLL:     aluOp = ALU_SLL;
          F3_SLT:     aluOp = ALU_SLT;
          F3_SLTU:    aluOp = ALU_SLTU;
          F3_XOR:     aluOp = ALU_XOR;
          F3_SRL_SRA: aluOp = s1Func7[5] ? ALU_SRA : ALU_SRL;
          F3_OR:      aluOp = ALU_OR;
          default:    aluOp = ALU_AND;
        endcase
      end
      OP_LUI: begin
        // The decoder has already positioned the upper immediate.
        operandB = s1Imm;
        aluOp    = ALU_PASSB;
        opValid  = 1'b1;
      end
      default: begin
        aluOp   = ALU_NOP;
        opValid = 1'b0;
      end
    endcase
  end

  exec_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (aluOp),
    .a      (s1Rs1),
    .b      (operandB),
    .result (aluResult)
  );

  always_ff @(posedge clk or negedge resetIn) begin
    if (!resetIn) begin
      s2We   <= 1'b0;
      s2Addr <= '0;
      s2Data <= '0;
    end else begin
      // x0 is hardwired to zero, so a write to it is never requested downstream.
      s2We   <= s1We && opValid && (s1Addr != '0);
      s2Addr <= s1Addr;
      s2Data <= aluResult;
    end
  end

  assign bus.writeEnableOut   = s2We;
  assign bus.writeBackAddrOut = s2Addr;
  assign bus.dataOut          = s2Data;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed vectors with hand-computed results.
// Latency: expectations are due exactly 2 clk edges after the vector is driven.
// Backpressure: none; vectors are driven back-to-back.
module tb_exec_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        we;
    logic [4:0]  addr;
    logic        expWe;
    logic [31:0] expData;
    string       name;
  } vec_t;

  typedef struct {
    int          due;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic clk;
  logic resetIn;
  int   edgeCnt;
  int   totalChecks;
  int   passedChecks;
  exp_t expQ[$];
  vec_t vecs[$];

  exec_if #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) bus ();

  exec_stage #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk     (clk),
    .resetIn (resetIn),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passedChecks++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic vec_t mk(input string name, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [31:0] rs1,
                              input logic [31:0] rs2, input logic [31:0] imm,
                              input logic we, input logic [4:0] addr,
                              input logic expWe, input logic [31:0] expData);
    vec_t v;
    v.name = name; v.op = op; v.f3 = f3; v.f7 = f7; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.we = we; v.addr = addr; v.expWe = expWe; v.expData = expData;
    return v;
  endfunction

  task automatic driveVec(input vec_t v);
    bus.dataReg1        = v.rs1;
    bus.dataReg2        = v.rs2;
    bus.immValueReg     = v.imm;
    bus.ALUopcodeReg    = v.op;
    bus.ALUFunc3Reg     = v.f3;
    bus.ALUFunc7Reg     = v.f7;
    bus.writeEnableReg  = v.we;
    bus.writeBackAddrIn = v.addr;
  endtask

  task automatic driveIdle();
    driveVec(mk("idle", 7'h00, 3'h0, 7'h00, '0, '0, '0, 1'b0, 5'd0, 1'b0, '0));
  endtask

  task automatic pushExp(input int due, input logic we, input logic [4:0] addr,
                         input logic [31:0] data, input string name);
    exp_t e;
    e.due = due; e.we = we; e.addr = addr; e.data = data; e.name = name;
    expQ.push_back(e);
  endtask

  // Drive at the falling edge: the next rising edge captures stage 1,
  // the one after that presents the result.
  task automatic issue(input vec_t v);
    @(negedge clk);
    driveVec(v);
    pushExp(edgeCnt + 2, v.expWe, v.addr, v.expData, v.name);
  endtask

  // Monitor: pops and compares whenever an expectation falls due.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      edgeCnt++;
      if (resetIn) begin
        while (expQ.size() > 0 && expQ[0].due < edgeCnt) begin
          totalChecks++;
          $display("FAIL %s: result not observed at edge %0d, expected by edge %0d",
                   expQ[0].name, edgeCnt, expQ[0].due);
          void'(expQ.pop_front());
        end
        if (expQ.size() > 0 && expQ[0].due == edgeCnt) begin
          exp_t e;
          e = expQ.pop_front();
          check({e.name, ".data"}, bus.dataOut, e.data);
          check({e.name, ".we"}, {31'b0, bus.writeEnableOut}, {31'b0, e.we});
          check({e.name, ".addr"}, {27'b0, bus.writeBackAddrOut}, {27'b0, e.addr});
        end
      end
    end
  end

  initial begin
    vec_t vA;
    vec_t vB;
    vec_t vC;
    edgeCnt      = 0;
    totalChecks  = 0;
    passedChecks = 0;
    resetIn      = 1'b0;
    driveIdle();

    // Reset state
    #1;
    check("reset.data", bus.dataOut, 32'h0);
    check("reset.we", {31'b0, bus.writeEnableOut}, 32'h0);
    check("reset.addr", {27'b0, bus.writeBackAddrOut}, 32'h0);

    // Release with an instruction driven immediately: edge 1 shows the
    // cleared stage 1 (all zero), edge 2 shows the instruction.
    vA = mk("first", 7'b0110011, 3'b000, 7'h00, 32'h5, 32'h3, 32'h0, 1'b1, 5'd5, 1'b1, 32'h8);
    @(negedge clk);
    resetIn = 1'b1;
    driveVec(vA);
    pushExp(edgeCnt + 1, 1'b0, 5'd0, 32'h0, "postReset");
    pushExp(edgeCnt + 2, vA.expWe, vA.addr, vA.expData, vA.name);

    vecs.push_back(mk("add",   7'b0110011, 3'b000, 7'h00, 32'h5, 32'h3, 32'h0,
                      1'b1, 5'd5, 1'b1, 32'h00000008));
    vecs.push_back(mk("subWrap", 7'b0110011, 3'b000, 7'h20, 32'h0, 32'h1, 32'h0,
                      1'b1, 5'd6, 1'b1, 32'hFFFFFFFF));
    vecs.push_back(mk("srai",  7'b0010011, 3'b101, 7'h20, 32'h80000000, 32'h0, 32'h00000404,
                      1'b1, 5'd7, 1'b1, 32'hF8000000));
    vecs.push_back(mk("srli",  7'b0010011, 3'b101, 7'h00, 32'h80000000, 32'h0, 32'h00000004,
                      1'b1, 5'd8, 1'b1, 32'h08000000));
    vecs.push_back(mk("slt",   7'b0110011, 3'b010, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0,
                      1'b1, 5'd9, 1'b1, 32'h1));
    vecs.push_back(mk("sltu",  7'b0110011, 3'b011, 7'h00, 32'hFFFFFFFF, 32'h1, 32'h0,
                      1'b1, 5'd10, 1'b1, 32'h0));
    vecs.push_back(mk("addi",  7'b0010011, 3'b000, 7'h7F, 32'h10, 32'h0, 32'hFFFFFFFF,
                      1'b1, 5'd11, 1'b1, 32'h0000000F));
    vecs.push_back(mk("lui",   7'b0110111, 3'b000, 7'h00, 32'hDEADBEEF, 32'h0, 32'h12345000,
                      1'b1, 5'd12, 1'b1, 32'h12345000));
    vecs.push_back(mk("addrZero", 7'b0110011, 3'b000, 7'h00, 32'h5, 32'h3, 32'h0,
                      1'b1, 5'd0, 1'b0, 32'h00000008));
    vecs.push_back(mk("badOpcode", 7'b1111111, 3'b000, 7'h00, 32'h5, 32'h3, 32'h7,
                      1'b1, 5'd13, 1'b0, 32'h0));
    vecs.push_back(mk("badFunc7", 7'b0110011, 3'b111, 7'h20, 32'hFF, 32'hFF, 32'h0,
                      1'b1, 5'd14, 1'b0, 32'h0));
    vecs.push_back(mk("xor",   7'b0110011, 3'b100, 7'h00, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,
                      1'b1, 5'd15, 1'b1, 32'h0FF00FF0));
    vecs.push_back(mk("sll",   7'b0110011, 3'b001, 7'h00, 32'h1, 32'h21, 32'h0,
                      1'b1, 5'd16, 1'b1, 32'h2));
    vecs.push_back(mk("sra",   7'b0110011, 3'b101, 7'h20, 32'h80000010, 32'h4, 32'h0,
                      1'b1, 5'd17, 1'b1, 32'hF8000001));
    vecs.push_back(mk("srl",   7'b0110011, 3'b101, 7'h00, 32'h80000000, 32'h1F, 32'h0,
                      1'b1, 5'd18, 1'b1, 32'h1));
    vecs.push_back(mk("or",    7'b0110011, 3'b110, 7'h00, 32'h0F, 32'hF0, 32'h0,
                      1'b1, 5'd19, 1'b1, 32'hFF));
    vecs.push_back(mk("and",   7'b0110011, 3'b111, 7'h00, 32'hFF, 32'h0F, 32'h0,
                      1'b1, 5'd20, 1'b1, 32'h0F));
    vecs.push_back(mk("addWrap", 7'b0110011, 3'b000, 7'h00, 32'hFFFFFFFF, 32'h2, 32'h0,
                      1'b1, 5'd21, 1'b1, 32'h1));
    vecs.push_back(mk("andi",  7'b0010011, 3'b111, 7'h00, 32'hFFFF, 32'h0, 32'hF0,
                      1'b1, 5'd22, 1'b1, 32'hF0));
    vecs.push_back(mk("ori",   7'b0010011, 3'b110, 7'h00, 32'h100, 32'h0, 32'h0F,
                      1'b1, 5'd23, 1'b1, 32'h10F));
    vecs.push_back(mk("xori",  7'b0010011, 3'b100, 7'h7F, 32'hFF, 32'h0, 32'hFFFFFFFF,
                      1'b1, 5'd24, 1'b1, 32'hFFFFFF00));
    vecs.push_back(mk("slti",  7'b0010011, 3'b010, 7'h7F, 32'hFFFFFFFE, 32'h0, 32'hFFFFFFFF,
                      1'b1, 5'd25, 1'b1, 32'h1));
    vecs.push_back(mk("sltiu", 7'b0010011, 3'b011, 7'h7F, 32'h5, 32'h0, 32'hFFFFFFFF,
                      1'b1, 5'd26, 1'b1, 32'h1));
    vecs.push_back(mk("slli",  7'b0010011, 3'b001, 7'h00, 32'h3, 32'h0, 32'h1F,
                      1'b1, 5'd27, 1'b1, 32'h80000000));
    vecs.push_back(mk("weLow", 7'b0110011, 3'b000, 7'h00, 32'h5, 32'h3, 32'h0,
                      1'b0, 5'd28, 1'b0, 32'h8));

    foreach (vecs[i]) issue(vecs[i]);

    // Mid-stream reset: A sits in stage 2, B in stage 1 when reset hits.
    vA = mk("preRstA", 7'b0110011, 3'b000, 7'h00, 32'h11, 32'h22, 32'h0, 1'b1, 5'd29, 1'b1, 32'h33);
    vB = mk("preRstB", 7'b0110111, 3'b000, 7'h00, 32'h0, 32'h0, 32'hABCDE000, 1'b1, 5'd30, 1'b1,
            32'hABCDE000);
    issue(vA);
    issue(vB);
    @(negedge clk);
    driveIdle();
    #2;
    resetIn = 1'b0;
    expQ.delete();
    #1;
    check("midReset.data", bus.dataOut, 32'h0);
    check("midReset.we", {31'b0, bus.writeEnableOut}, 32'h0);
    check("midReset.addr", {27'b0, bus.writeBackAddrOut}, 32'h0);

    // Release: the discarded B must not reappear; C lands 2 edges later.
    vC = mk("postRstC", 7'b0010011, 3'b000, 7'h00, 32'h7, 32'h0, 32'h3, 1'b1, 5'd31, 1'b1, 32'hA);
    @(negedge clk);
    resetIn = 1'b1;
    driveVec(vC);
    pushExp(edgeCnt + 1, 1'b0, 5'd0, 32'h0, "rstFlush");
    pushExp(edgeCnt + 2, vC.expWe, vC.addr, vC.expData, vC.name);
    @(negedge clk);
    driveIdle();

    // Drain with a bounded wait.
    for (int k = 0; k < 10 && expQ.size() > 0; k++) @(negedge clk);
    while (expQ.size() > 0) begin
      totalChecks++;
      $display("FAIL %s: result never observed (due edge %0d)", expQ[0].name, expQ[0].due);
      void'(expQ.pop_front());
    end

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 resetIn  input  1  asynchronous, active-low reset.
REQ-005 dataReg1  input  DATA_W  rs1 operand from the register file.
REQ-006 dataReg2  input  DATA_W  rs2 operand from the register file.
REQ-007 immValueReg  input  DATA_W  immediate, fully sign-extended and positioned by the decoder (LUI value already shifted left 12).
REQ-008 ALUopcodeReg  input  7  instruction opcode.
REQ-009 ALUFunc3Reg  input  3  instruction func3.
REQ-010 ALUFunc7Reg  input  7  instruction func7.
REQ-011 writeEnableReg  input  1  destination register write request.
REQ-012 writeBackAddrIn  input  REG_ADDR_W  destination register index.
REQ-013 writeEnableOut  output  1  registered write enable toward the MEM/WB stage.
REQ-014 writeBackAddrOut  output  REG_ADDR_W  registered destination index.
REQ-015 dataOut  output  DATA_W  registered ALU result.

Function
REQ-016 The block SHALL be two register stages:
- stage 1 (DEC/EX) captures all inputs every clk edge;
- an ALU-control decoder and a combinational ALU operate on stage-1 contents;
- stage 2 (EX/MEM) captures the result, write enable and address.
REQ-017 Latency SHALL be exactly 2 clk edges from input to outputs, with one new instruction accepted per cycle, no stalls and no handshake.
REQ-018 Opcode 0110011 (R-type) SHALL select the following operations on rs1, rs2:
- by func3: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND;
- func7=0100000 selects SUB for func3 000 and SRA for func3 101.
REQ-019 Opcode 0010011 (I-type) SHALL select ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI and SRAI on rs1 and imm.
- SRAI is selected when func7[5]=1.
- The shift amount is imm[4:0].
REQ-020 Opcode 0110111 (LUI) SHALL produce result = imm.
REQ-021 Arithmetic SHALL wrap modulo 2^DATA_W, with no overflow flag.
REQ-022 Register shifts SHALL use rs2[4:0].
REQ-023 SRA and SRAI SHALL replicate the sign bit.
REQ-024 SLT and SLTI SHALL compare signed operands; SLTU and SLTIU SHALL compare unsigned operands; each SHALL produce 0 or 1 zero-extended.
REQ-025 Any other opcode, or an undefined func7 combination, SHALL produce result 0 and force writeEnableOut=0.
REQ-026 writeEnableOut SHALL be forced to 0 when the destination address is 0.
REQ-027 writeBackAddrOut SHALL always carry the captured address unchanged.

Reset
REQ-028 While resetIn=0, both stages SHALL clear asynchronously: writeEnableOut=0, writeBackAddrOut=0, dataOut=0, and all stage-1 fields=0.
REQ-029 After resetIn rises, the first valid output SHALL appear on the 2nd clk edge.
REQ-030 A reset asserted mid-operation SHALL discard both in-flight instructions.

Structure
REQ-031 A shared package exec_pkg SHALL hold:
- the opcode constants (OP_R=0110011, OP_I=0010011, OP_LUI=0110111);
- the func3 codes;
- the ALU operation enum (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB, NOP).
REQ-032 The combinational ALU SHALL be one sub-module, exec_alu, taking the op enum, two operands and a DATA_W result.
REQ-033 The ALU-control decoding and both register stages SHALL reside in exec_stage.

Verification
REQ-034 ADD: rs1=0x00000005, rs2=0x00000003, opcode 0110011, f3=000, f7=0, addr=5, we=1 -> after 2 edges dataOut=0x00000008, addr=5, we=1.
REQ-035 SUB wrap: rs1=0, rs2=1, f7=0100000 -> dataOut=0xFFFFFFFF.
REQ-036 SRAI: rs1=0x80000000, imm=0x00000404 (f7[5]=1, shamt 4) -> 0xF8000000; SRLI with the same rs1 and imm=0x00000004 -> 0x08000000.
REQ-037 SLT vs SLTU: rs1=0xFFFFFFFF, rs2=1 -> SLT=1, SLTU=0.
REQ-038 Back-to-back: ADDI then LUI (imm=0x12345000) on consecutive cycles -> results on consecutive cycles; addr=0 or opcode 1111111 -> we=0.
REQ-039 Reset: drive resetIn=0 mid-stream -> all outputs 0 immediately; after release, outputs resume 2 edges later.
